formula_seq_ctrl: RTL

FORMULA_SEQ_CTRL -- requirements
Module: formula_seq_ctrl

---
 rtl/formula_pkg.sv | 23 ++
 rtl/lfsr_fib.sv | 32 +++
 rtl/formula_seq_ctrl.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/formula_pkg.sv
// Shared constants for the start-light sequencer: FSM state encodings and LFSR seed/taps.
package formula_pkg;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_FILL   = 3'd1;
  localparam logic [2:0] ST_HOLD   = 3'd2;
  localparam logic [2:0] ST_TIMING = 3'd3;
  localparam logic [2:0] ST_FAULT  = 3'd4;

  typedef enum logic [2:0] {
    IDLE   = ST_IDLE,
    FILL   = ST_FILL,
    HOLD   = ST_HOLD,
    TIMING = ST_TIMING,
    FAULT  = ST_FAULT
  } state_e;

  localparam int          LFSR_W    = 16;
  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  // Taps 16,14,13,11 expressed as a mask over bits [15:0].
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

endpackage

// File: rtl/lfsr_fib.sv
// Fibonacci LFSR, shifts left with XOR of tapped bits fed into bit 0.
// A zero state (unreachable from a nonzero seed) is forced back to the seed.
module lfsr_fib
  import formula_pkg::*;
#(
  parameter int               WIDTH = LFSR_W,
  parameter logic [WIDTH-1:0] SEED  = WIDTH'(LFSR_SEED),
  parameter logic [WIDTH-1:0] TAPS  = WIDTH'(LFSR_TAPS)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] q_q;
  logic             fb_d;

  assign fb_d = ^(q_q & TAPS);
  assign q    = q_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      q_q <= SEED;
    end else if (q_q == '0) begin
      q_q <= SEED;
    end else if (en) begin
      q_q <= {q_q[WIDTH-2:0], fb_d};
    end
  end

endmodule

// File: rtl/formula_seq_ctrl.sv
// Start-light sequencer: fill lights per tick, random hold, lights out, then time the reaction.
// All outputs registered; react in FILL/HOLD is a false start that parks in FAULT until re-triggered.
module formula_seq_ctrl
  import formula_pkg::*;
#(
  parameter int NUM_LEDS  = 10,
  parameter int RAND_BITS = 6,
  parameter int MIN_DELAY = 8,
  parameter int RT_W      = 12
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                tick,
  input  logic                trigger,
  input  logic                react,
  output logic [NUM_LEDS-1:0] ledr,
  output logic                busy,
  output logic                lights_out,
  output logic                react_valid,
  output logic [RT_W-1:0]     react_time,
  output logic                false_start
);

  localparam int DLY_W = $clog2(MIN_DELAY + (1 << RAND_BITS));

  state_e              state_q;
  logic [NUM_LEDS-1:0] ledr_q;
  logic                busy_q;
  logic                lights_out_q;
  logic                react_valid_q;
  logic [RT_W-1:0]     react_time_q;
  logic                false_start_q;
  logic                fault_ph_q;
  logic [DLY_W-1:0]    delay_cnt_q;
  logic [RT_W-1:0]     rt_cnt_q;

  logic [LFSR_W-1:0]   lfsr;
  logic [DLY_W-1:0]    delay_load_d;
  logic                unused_lfsr_bits;

  lfsr_fib #(
    .WIDTH (LFSR_W),
    .SEED  (LFSR_SEED),
    .TAPS  (LFSR_TAPS)
  ) u_lfsr (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (1'b1),
    .q     (lfsr)
  );

  assign delay_load_d     = DLY_W'(MIN_DELAY) + DLY_W'(lfsr[RAND_BITS-1:0]);
  assign unused_lfsr_bits = ^lfsr[LFSR_W-1:RAND_BITS];

  assign ledr        = ledr_q;
  assign busy        = busy_q;
  assign lights_out  = lights_out_q;
  assign react_valid = react_valid_q;
  assign react_time  = react_time_q;
  assign false_start = false_start_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      ledr_q        <= '0;
      busy_q        <= 1'b0;
      lights_out_q  <= 1'b0;
      react_valid_q <= 1'b0;
      react_time_q  <= '0;
      false_start_q <= 1'b0;
      fault_ph_q    <= 1'b0;
      delay_cnt_q   <= '0;
      rt_cnt_q      <= '0;
    end else begin
      lights_out_q  <= 1'b0;
      react_valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (trigger) begin
            state_q <= FILL;
            ledr_q  <= '0;
            busy_q  <= 1'b1;
          end
        end
        FILL: begin
          if (react) begin
            state_q       <= FAULT;
            busy_q        <= 1'b0;
            false_start_q <= 1'b1;
            fault_ph_q    <= 1'b0;
          end else if (tick) begin
            ledr_q <= {ledr_q[NUM_LEDS-2:0], 1'b1};
            if (&ledr_q[NUM_LEDS-2:0]) begin
              state_q     <= HOLD;
              delay_cnt_q <= delay_load_d;
            end
          end
        end
        HOLD: begin
          if (react) begin
            state_q       <= FAULT;
            busy_q        <= 1'b0;
            false_start_q <= 1'b1;
            fault_ph_q    <= 1'b0;
          end else if (tick) begin
            delay_cnt_q <= delay_cnt_q - DLY_W'(1);
            if (delay_cnt_q == DLY_W'(1)) begin
              state_q      <= TIMING;
              ledr_q       <= '0;
              lights_out_q <= 1'b1;
              rt_cnt_q     <= '0;
            end
          end
        end
        TIMING: begin
          // A same-cycle tick is dropped so the reported time is the pre-increment count.
          if (react) begin
            state_q       <= IDLE;
            busy_q        <= 1'b0;
            react_time_q  <= rt_cnt_q;
            react_valid_q <= 1'b1;
          end else if (tick) begin
            if (&rt_cnt_q) begin
              state_q       <= IDLE;
              busy_q        <= 1'b0;
              react_time_q  <= '1;
              react_valid_q <= 1'b1;
            end else begin
              rt_cnt_q <= rt_cnt_q + RT_W'(1);
            end
          end
        end
        FAULT: begin
          if (trigger) begin
            state_q       <= FILL;
            ledr_q        <= '0;
            busy_q        <= 1'b1;
            false_start_q <= 1'b0;
          end else if (tick) begin
            ledr_q     <= fault_ph_q ? '0 : '1;
            fault_ph_q <= ~fault_ph_q;
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

endmodule
